// File: rtl/clock_edge_tracker.sv
// Tracks a slow clock-like input in the fast clock domain: edge strobes, period measurement, lock.
// Define CLOCK_EDGE_TRACKER_HIGH_TIME_EN to build the rise-to-fall high_time counter.
module clock_edge_tracker #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned TOL         = 1,
  parameter int unsigned MAX_PERIOD  = 65535
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_clock,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout,
  output logic [CNT_W-1:0] high_time
);

  localparam int unsigned MatchW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned ArmW   = $clog2(SYNC_STAGES + 2);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StAcquire = 2'd1;
  localparam logic [1:0] StLocked  = 2'd2;

  localparam logic [CNT_W-1:0]  CntMax    = CNT_W'(MAX_PERIOD - 1);
  localparam logic [ArmW-1:0]   ArmDone   = ArmW'(SYNC_STAGES + 1);
  localparam logic [MatchW-1:0] LockMatch = MatchW'(LOCK_COUNT);
  localparam logic [CNT_W:0]    TolW      = (CNT_W + 1)'(TOL);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [ArmW-1:0]        arm_q;
  logic                   rise_q, fall_q;
  logic                   sync_w, armed;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  ref_q, ref_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [MatchW-1:0] match_q, match_d, match_inc;
  logic              valid_q, valid_d;
  logic              locked_q, locked_d;
  logic [CNT_W:0]    meas, diff;
  logic              in_tol, tmo;

  assign sync_w = sync_q[SYNC_STAGES-1];
  assign armed  = (arm_q == ArmDone);

  // Edge detection stays disarmed until the synchronizer has flushed post-reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      arm_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_clock};
      prev_q <= sync_w;
      if (!armed) arm_q <= arm_q + ArmW'(1);
      rise_q <= armed & sync_w & ~prev_q;
      fall_q <= armed & ~sync_w & prev_q;
    end
  end

  assign meas      = {1'b0, cnt_q} + (CNT_W + 1)'(1);
  assign diff      = (meas >= {1'b0, ref_q}) ? (meas - {1'b0, ref_q}) : ({1'b0, ref_q} - meas);
  assign in_tol    = (diff <= TolW);
  assign tmo       = (state_q != StIdle) && (cnt_q == CntMax);
  assign match_inc = match_q + MatchW'(1);

  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    period_d = period_q;
    match_d  = match_q;
    valid_d  = valid_q;
    locked_d = locked_q;

    if (state_q == StIdle || rise_q || tmo) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    // Timeout wins over a coincident rise, which is dropped.
    if (tmo) begin
      state_d  = StIdle;
      locked_d = 1'b0;
      valid_d  = 1'b0;
      period_d = '0;
      match_d  = '0;
    end else if (rise_q) begin
      case (state_q)
        StIdle: begin
          state_d = StAcquire;
          match_d = '0;
        end
        StAcquire: begin
          period_d = meas[CNT_W-1:0];
          if (!valid_q) begin
            valid_d = 1'b1;
            ref_d   = meas[CNT_W-1:0];
            match_d = '0;
          end else if (in_tol) begin
            match_d = match_inc;
            if (match_inc == LockMatch) begin
              state_d  = StLocked;
              locked_d = 1'b1;
            end
          end else begin
            ref_d   = meas[CNT_W-1:0];
            match_d = '0;
          end
        end
        StLocked: begin
          period_d = meas[CNT_W-1:0];
          if (!in_tol) begin
            state_d  = StAcquire;
            locked_d = 1'b0;
            ref_d    = meas[CNT_W-1:0];
            match_d  = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      ref_q    <= '0;
      period_q <= '0;
      match_q  <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ref_q    <= ref_d;
      period_q <= period_d;
      match_q  <= match_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
    end
  end

  assign rise_pulse   = rise_q;
  assign fall_pulse   = fall_q;
  assign period       = period_q;
  assign period_valid = valid_q;
  assign locked       = locked_q;
  assign timeout      = tmo;

`ifdef CLOCK_EDGE_TRACKER_HIGH_TIME_EN
  logic [CNT_W-1:0] hcnt_q, high_q;
  logic             hseen_q;

  // hseen_q blocks a fall that has no rise behind it since the last idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hcnt_q  <= '0;
      high_q  <= '0;
      hseen_q <= 1'b0;
    end else if (tmo) begin
      hcnt_q  <= '0;
      high_q  <= '0;
      hseen_q <= 1'b0;
    end else begin
      if (rise_q) begin
        hcnt_q  <= '0;
        hseen_q <= 1'b1;
      end else if (hseen_q && hcnt_q != '1) begin
        hcnt_q <= hcnt_q + CNT_W'(1);
      end
      if (fall_q && hseen_q) begin
        high_q <= (hcnt_q == '1) ? hcnt_q : hcnt_q + CNT_W'(1);
      end
    end
  end

  assign high_time = high_q;
`else
  assign high_time = '0;
`endif

endmodule

// File: tb/tb_clock_edge_tracker.sv
// Self-checking bench for clock_edge_tracker: vector table with a period scoreboard plus
// hand-written sequences for arming, async reset and timeout.
`timescale 1ns/1ps
module tb_clock_edge_tracker;

  localparam int CntW = 16;
`ifdef CLOCK_EDGE_TRACKER_HIGH_TIME_EN
  localparam int ExpHigh = 5;
`else
  localparam int ExpHigh = 0;
`endif

  logic            clock, reset, in_clock;
  logic            rise_pulse, fall_pulse, period_valid, locked, timeout;
  logic [CntW-1:0] period, high_time;

  clock_edge_tracker #(
    .SYNC_STAGES(2),
    .CNT_W      (CntW),
    .LOCK_COUNT (4),
    .TOL        (1),
    .MAX_PERIOD (64)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_clock    (in_clock),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .period      (period),
    .period_valid(period_valid),
    .locked      (locked),
    .timeout     (timeout),
    .high_time   (high_time)
  );

  typedef struct {
    int period;
    int high;
    bit locked;
  } vec_t;

  vec_t vecs[13];
  vec_t sb_q[$];
  vec_t exp_cur;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0, last_rise_cyc = 0, timeout_cyc = 0, timeout_cnt = 0;
  bit mon_en = 0, have_rise = 0, pending = 0, post_to = 0, toggle_en = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint all_outs();
    return longint'({rise_pulse, fall_pulse, period, period_valid, locked, timeout, high_time});
  endfunction

  // Scoreboard monitor: each rise after the first pops the period that rise closes.
  always @(negedge clock) begin
    cyc++;
    if (post_to) begin
      post_to = 0;
      check("timeout_single", timeout, 0);
      check("to_locked", locked, 0);
      check("to_valid", period_valid, 0);
      check("to_period", period, 0);
      check("to_high", high_time, 0);
    end
    if (pending) begin
      pending = 0;
      check("sb_period", period, exp_cur.period);
      check("sb_locked", locked, exp_cur.locked);
      check("sb_valid", period_valid, 1);
      check("sb_high", high_time, ExpHigh);
    end
    if (mon_en) begin
      check("rise_fall_excl", rise_pulse & fall_pulse, 0);
      if (rise_pulse) begin
        if (have_rise) begin
          check("sb_nonempty", sb_q.size() != 0, 1);
          if (sb_q.size() != 0) begin
            exp_cur = sb_q.pop_front();
            pending = 1;
          end
        end
        have_rise     = 1;
        last_rise_cyc = cyc;
      end
      if (fall_pulse && have_rise) check("fall_delay", cyc - last_rise_cyc, 5);
      if (timeout) begin
        timeout_cnt++;
        timeout_cyc = cyc;
        post_to     = 1;
        have_rise   = 0;
      end
    end
  end

  always @(posedge clock) begin
    if (toggle_en) begin
      #1 in_clock = ~in_clock;
    end
  end

  task automatic do_reset(input logic lvl);
    mon_en   = 0;
    reset    = 1'b0;
    in_clock = lvl;
    sb_q.delete();
    have_rise = 0;
    pending   = 0;
    post_to   = 0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic drive(input logic v, input int n);
    in_clock = v;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic run_vecs(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      sb_q.push_back(vecs[i]);
      drive(1'b1, vecs[i].high);
      drive(1'b0, vecs[i].period - vecs[i].high);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int nr, last, after;
    bit got, got_fall;

    vecs = '{'{10, 5, 0}, '{10, 5, 0}, '{10, 5, 0}, '{10, 5, 0}, '{10, 5, 1},
             '{11, 5, 1}, '{9, 5, 1}, '{10, 5, 1},
             '{14, 5, 0}, '{14, 5, 0}, '{14, 5, 0}, '{14, 5, 0}, '{14, 5, 1}};
    reset    = 1'b0;
    in_clock = 1'b0;
    #12;
    check("reset_outputs", all_outs(), 0);

    // Toggle every cycle from reset release.
    do_reset(1'b0);
    toggle_en = 1;
    nr = 0; last = 0; after = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (after == 2) begin
        check("tog_valid_after2", period_valid, 1);
        check("tog_period", period, 2);
      end
      if (after == 6) check("tog_locked_after6", locked, 1);
      after = 0;
      if (rise_pulse) begin
        nr++;
        if (nr > 1) check("tog_rise_gap", c - last, 2);
        last = c;
        if (nr == 2) check("tog_valid_at2", period_valid, 0);
        if (nr == 6) check("tog_locked_at6", locked, 0);
        after = nr;
      end
    end
    toggle_en = 0;
    check("tog_rise_count_ok", nr >= 10, 1);

    // Table run: lock at 10, tolerance hold, re-acquire at 14, then timeout.
    @(posedge clock); #1;
    do_reset(1'b0);
    drive(1'b0, 6);
    mon_en = 1;
    run_vecs(0, 12);
    drive(1'b1, 5);
    in_clock = 1'b0;
    for (int c = 0; c < 200 && timeout_cnt == 0; c++) @(negedge clock);
    repeat (3) @(negedge clock);
    check("timeout_count", timeout_cnt, 1);
    check("timeout_delay", timeout_cyc - last_rise_cyc, 64);

    // Async reset pulse while locked, then a full re-acquire.
    @(posedge clock); #1;
    do_reset(1'b0);
    drive(1'b0, 6);
    mon_en = 1;
    run_vecs(0, 5);
    drive(1'b1, 5);
    drive(1'b0, 8);
    @(negedge clock);
    check("pre_reset_locked", locked, 1);
    #2 reset = 1'b0;
    mon_en = 0;
    sb_q.delete();
    have_rise = 0;
    pending   = 0;
    #1 check("async_reset_outputs", all_outs(), 0);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    drive(1'b0, 6);
    mon_en = 1;
    run_vecs(0, 4);
    drive(1'b1, 5);
    drive(1'b0, 8);

    // in_clock high across reset release: no rise, first strobe is a fall.
    do_reset(1'b1);
    nr = 0;
    repeat (10) begin
      @(negedge clock);
      if (rise_pulse) nr++;
    end
    check("held_high_no_rise", nr, 0);
    @(posedge clock); #1;
    in_clock = 1'b0;
    got = 0; got_fall = 0;
    for (int c = 0; c < 12 && !got; c++) begin
      @(negedge clock);
      if (rise_pulse || fall_pulse) begin
        got      = 1;
        got_fall = fall_pulse && !rise_pulse;
      end
    end
    check("held_high_strobe_seen", got, 1);
    check("held_high_first_fall", got_fall, 1);
    @(negedge clock);
    check("held_high_high_time", high_time, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
